stream_mux_arb: RTL and testbench
=================================

// Module: stream_mux_arb
// PURPOSE
//   Parametrised N-channel, W-bit streaming multiplexer with valid/ready handshakes.
//   Selects one input stream per packet by round-robin, fixed-priority or external select.
//   Forwards beats through one registered output stage.
//   Sits between multiple producers and a single shared consumer. Successor to the 4:1 bit muxes.
// PARAMETERS
//   N_CH  4  number of input channels (>=1)
//   DW    8  data width per channel, bits
//   MODE  0  0 = round-robin, 1 = fixed priority (lowest index wins), 2 = external select
//   SELW  localparam = max(1, clog2(N_CH)); width of channel indices
// PORTS
//   clk       in   1        clock; all state updates on rising edge
//   rst_n     in   1        asynchronous, active-low reset
//   in_valid  in   N_CH     per-channel beat valid
//   in_data   in   N_CH*DW  channel i occupies bits [i*DW +: DW]
//   in_last   in   N_CH     per-channel end-of-packet marker
//   in_ready  out  N_CH     per-channel accept; at most one bit high (one-hot or zero)
//   ext_sel   in   SELW     channel request; used only when MODE=2
//   out_valid out  1        output register holds a beat
//   out_data  out  DW       registered beat data
//   out_last  out  1        registered end-of-packet marker
//   out_ch    out  SELW     index of the source channel of the current beat
//   out_ready in   1        consumer accept
// BEHAVIOUR
//   Reset (async, rst_n=0):
//     - out_valid=0, out_data=0, out_last=0, out_ch=0.
//     - rr_ptr=0, state=IDLE.
//     - in_ready=0 while rst_n=0.
//   load_en = !out_valid || out_ready (output reg empty or draining this cycle).
//   Transfer on channel i when in_valid[i] && in_ready[i].
//   Output reg loads data/last/ch on that same edge; out_valid then =1.
//   If out_ready && out_valid with no new load, out_valid -> 0.
//   Latency: input transfer to out_valid = 1 cycle. Full throughput (1 beat/cycle) when out_ready held high.
//   Output hold: out_data/out_last/out_ch stay stable while out_valid && !out_ready.
//   FSM:
//     - IDLE: compute grant from requests in_valid.
//       - MODE0: first valid at or after rr_ptr, wrapping N_CH-1 -> 0.
//       - MODE1: lowest valid index.
//       - MODE2: ext_sel, only if ext_sel < N_CH and in_valid[ext_sel]; otherwise no grant.
//       - in_ready[grant] = load_en.
//       - On transfer with in_last=1: stay IDLE and update rr_ptr.
//       - On transfer with in_last=0: latch grant into lock_ch, go LOCK.
//     - LOCK: in_ready[lock_ch] = load_en; all other channels see in_ready=0.
//       - ext_sel is ignored in LOCK.
//       - A transfer with in_last=1 returns to IDLE and updates rr_ptr.
//   rr_ptr update: rr_ptr <= (granted_ch == N_CH-1) ? 0 : granted_ch+1, on packet end only. MODE0 only; MODE1/2 leave rr_ptr at 0.
//   Boundary conditions:
//     - Locked channel drops in_valid mid-packet: bubble. No other channel is granted until that packet's last beat.
//     - Drain and load in the same cycle: new beat replaces old. out_valid stays 1; no beat lost or duplicated.
//     - No request in IDLE: all in_ready=0, state unchanged.
//     - N_CH=1: grant is always 0; out_ch=0.
//     - Reset mid-packet: partial packet abandoned, in-flight output beat discarded. Arbitration restarts from channel 0.
//     - Grant is decided combinationally from the current in_valid. in_ready must not depend on in_ready of other channels.
// STRUCTURE
//   Package stream_mux_pkg:
//     - MODE_RR=0, MODE_FIXED=1, MODE_EXT=2 constants.
//     - FSM state typedef {IDLE, LOCK}.
//     - clog2 helper function.
//   Sub-module rr_arbiter (N_CH, SELW): req + ptr -> one-hot grant + index; combinational.
//   Top holds the FSM, lock_ch, rr_ptr, output register and data select.
// TESTING
//   1. N_CH=4, MODE0: all 4 valid, 1-beat packets, out_ready=1.
//      -> out_ch sequence 0,1,2,3,0; one beat/cycle; first out_valid 1 cycle after first transfer.
//   2. MODE0: ch2 sends 3-beat packet (last on beat 3) while ch0, ch1 valid.
//      -> out_ch=2,2,2 contiguous, then 3 if valid else 0 (wrap); in_ready[0], in_ready[1] stay 0 during packet.
//   3. Backpressure: out_ready=0 for 5 cycles with out_valid=1, data 0xA5.
//      -> out_data stays 0xA5, all in_ready=0; resumes on out_ready=1 with no loss or duplicate.
//   4. MODE1: ch1 and ch3 valid continuously, 1-beat packets.
//      -> only ch1 granted; ch3 in_ready stays 0 until ch1 drops valid.
//   5. MODE2: ext_sel=3 with ch3 idle, ch0 valid -> no grant.
//      ext_sel=3 with ch3 valid -> ch3 granted.
//      ext_sel changed mid-packet -> lock held on ch3.
//   6. Assert rst_n=0 during beat 2 of a 4-beat ch1 packet.
//      -> outputs 0 immediately (async); after release, ch0 granted first when ch0 and ch1 both valid.

Source files
------------

// File: rtl/stream_mux_pkg.sv
// Shared constants, FSM state type and width helper for the stream multiplexer.
package stream_mux_pkg;

  localparam int MODE_RR    = 0;
  localparam int MODE_FIXED = 1;
  localparam int MODE_EXT   = 2;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

  // Ceiling log2. Returns 0 for n <= 1.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority arbiter: the first requester at or after
// ptr_i wins, wrapping from N_CH-1 back to 0. With ptr_i = 0 it behaves as
// a fixed lowest-index-wins arbiter.
module rr_arbiter #(
  parameter int N_CH = 4,
  parameter int SELW = 2
) (
  input  logic [N_CH-1:0] req_i,
  input  logic [SELW-1:0] ptr_i,
  output logic [N_CH-1:0] gnt_o,
  output logic [SELW-1:0] gnt_idx_o,
  output logic            gnt_vld_o
);

  int              idx;
  logic [SELW-1:0] idx_s;

  // Scan requesters starting at the pointer and keep the first hit.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    gnt_vld_o = 1'b0;
    idx       = 0;
    idx_s     = '0;
    for (int off = 0; off < N_CH; off++) begin
      idx   = (int'(ptr_i) + off) % N_CH;
      idx_s = SELW'(idx);
      if (!gnt_vld_o && req_i[idx_s]) begin
        gnt_vld_o    = 1'b1;
        gnt_idx_o    = idx_s;
        gnt_o[idx_s] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stream_mux_arb.sv
// N-channel valid/ready stream multiplexer with packet-level arbitration and
// a single registered output stage.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | between packets; grant comes from the arbiter or ext_sel
//   LOCK  | mid-packet; only lock_ch may transfer until its last beat
module stream_mux_arb
  import stream_mux_pkg::*;
#(
  parameter  int N_CH = 4,
  parameter  int DW   = 8,
  parameter  int MODE = 0,
  localparam int SELW = (clog2(N_CH) > 1) ? clog2(N_CH) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_CH-1:0]    in_valid,
  input  logic [N_CH*DW-1:0] in_data,
  input  logic [N_CH-1:0]    in_last,
  output logic [N_CH-1:0]    in_ready,
  input  logic [SELW-1:0]    ext_sel,
  output logic               out_valid,
  output logic [DW-1:0]      out_data,
  output logic               out_last,
  output logic [SELW-1:0]    out_ch,
  input  logic               out_ready
);

  arb_state_e      state_q, state_d;
  logic [SELW-1:0] lock_ch_q, lock_ch_d;
  logic [SELW-1:0] rr_ptr_q, rr_ptr_d;
  logic            out_valid_q;
  logic [DW-1:0]   out_data_q;
  logic            out_last_q;
  logic [SELW-1:0] out_ch_q;

  logic [SELW-1:0] arb_ptr;
  logic [N_CH-1:0] arb_gnt;
  logic [SELW-1:0] arb_idx;
  logic            arb_vld;

  logic            load_en;
  logic [SELW-1:0] sel;
  logic            grant_vld;
  logic [N_CH-1:0] ready_oh;
  logic            xfer;
  logic [DW-1:0]   beat_data;
  logic            beat_last;

  // Fixed priority is the rotating arbiter pinned at channel 0.
  assign arb_ptr = (MODE == MODE_RR) ? rr_ptr_q : '0;

  rr_arbiter #(
    .N_CH (N_CH),
    .SELW (SELW)
  ) u_arb (
    .req_i     (in_valid),
    .ptr_i     (arb_ptr),
    .gnt_o     (arb_gnt),
    .gnt_idx_o (arb_idx),
    .gnt_vld_o (arb_vld)
  );

  assign load_en = !out_valid_q || out_ready;

  // Pick the serving channel: locked channel, external request or arbiter grant.
  always_comb begin
    sel       = '0;
    grant_vld = 1'b0;
    ready_oh  = '0;
    if (state_q == LOCK) begin
      sel       = lock_ch_q;
      grant_vld = 1'b1;
      for (int i = 0; i < N_CH; i++) ready_oh[i] = (lock_ch_q == SELW'(i));
    end else if (MODE == MODE_EXT) begin
      for (int i = 0; i < N_CH; i++) begin
        if (ext_sel == SELW'(i) && in_valid[i]) begin
          sel         = SELW'(i);
          grant_vld   = 1'b1;
          ready_oh[i] = 1'b1;
        end
      end
    end else begin
      sel       = arb_idx;
      grant_vld = arb_vld;
      ready_oh  = arb_gnt;
    end
  end

  // Ready is held low during reset so nothing is accepted before release.
  assign in_ready  = (rst_n && load_en && grant_vld) ? ready_oh : '0;
  assign xfer      = |(in_ready & in_valid);
  assign beat_data = in_data[int'(sel)*DW +: DW];
  assign beat_last = in_last[sel];

  // Packet framing: lock on a non-last beat, release and advance the pointer on the last.
  always_comb begin
    state_d   = state_q;
    lock_ch_d = lock_ch_q;
    rr_ptr_d  = rr_ptr_q;
    if (xfer) begin
      if (beat_last) begin
        state_d = IDLE;
        if (MODE == MODE_RR) begin
          rr_ptr_d = (sel == SELW'(N_CH - 1)) ? '0 : sel + 1'b1;
        end
      end else if (state_q == IDLE) begin
        state_d   = LOCK;
        lock_ch_d = sel;
      end
    end
  end

  // Arbitration state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      lock_ch_q <= '0;
      rr_ptr_q  <= '0;
    end else begin
      state_q   <= state_d;
      lock_ch_q <= lock_ch_d;
      rr_ptr_q  <= rr_ptr_d;
    end
  end

  // Output stage: load on transfer (also when draining), otherwise clear on drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_ch_q    <= '0;
    end else if (xfer) begin
      out_valid_q <= 1'b1;
      out_data_q  <= beat_data;
      out_last_q  <= beat_last;
      out_ch_q    <= sel;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_stream_mux_arb.sv
// Bench for stream_mux_arb: a round-robin instance checked through an
// expected-beat scoreboard, plus fixed-priority and external-select
// instances checked cycle by cycle.
module tb_stream_mux_arb;

  logic clk;
  logic rst_n;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   n_pop  = 0;

  // Round-robin instance
  logic [3:0]  r_v, r_l, r_rdy;
  logic [31:0] r_d;
  logic [1:0]  r_es, r_och;
  logic        r_ov, r_ol, r_or;
  logic [7:0]  r_od;
  // Fixed-priority instance
  logic [3:0]  f_v, f_l, f_rdy;
  logic [31:0] f_d;
  logic [1:0]  f_es, f_och;
  logic        f_ov, f_ol, f_or;
  logic [7:0]  f_od;
  // External-select instance
  logic [3:0]  e_v, e_l, e_rdy;
  logic [31:0] e_d;
  logic [1:0]  e_es, e_och;
  logic        e_ov, e_ol, e_or;
  logic [7:0]  e_od;

  stream_mux_arb #(.N_CH(4), .DW(8), .MODE(0)) dut_rr (
    .clk(clk), .rst_n(rst_n), .in_valid(r_v), .in_data(r_d), .in_last(r_l),
    .in_ready(r_rdy), .ext_sel(r_es), .out_valid(r_ov), .out_data(r_od),
    .out_last(r_ol), .out_ch(r_och), .out_ready(r_or));

  stream_mux_arb #(.N_CH(4), .DW(8), .MODE(1)) dut_fx (
    .clk(clk), .rst_n(rst_n), .in_valid(f_v), .in_data(f_d), .in_last(f_l),
    .in_ready(f_rdy), .ext_sel(f_es), .out_valid(f_ov), .out_data(f_od),
    .out_last(f_ol), .out_ch(f_och), .out_ready(f_or));

  stream_mux_arb #(.N_CH(4), .DW(8), .MODE(2)) dut_ex (
    .clk(clk), .rst_n(rst_n), .in_valid(e_v), .in_data(e_d), .in_last(e_l),
    .in_ready(e_rdy), .ext_sel(e_es), .out_valid(e_ov), .out_data(e_od),
    .out_last(e_ol), .out_ch(e_och), .out_ready(e_or));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] ch;
    logic [7:0] d;
    logic       l;
  } beat_t;

  beat_t exp_q[$];
  beat_t sb_exp;

  task automatic push(input logic [1:0] ch, input logic [7:0] d, input logic l);
    exp_q.push_back('{ch: ch, d: d, l: l});
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_r(input int c, input logic v, input logic l, input logic [7:0] d);
    r_v[c] = v;
    r_l[c] = l;
    r_d[c*8 +: 8] = d;
  endtask

  task automatic set_e(input int c, input logic v, input logic l, input logic [7:0] d);
    e_v[c] = v;
    e_l[c] = l;
    e_d[c*8 +: 8] = d;
  endtask

  // Scoreboard monitor: every beat the consumer accepts must match the next expected beat.
  always @(negedge clk) begin
    if (rst_n && r_ov && r_or) begin
      n_chk++;
      n_pop++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got ch=%0d data=%0h last=%0b expected no beat", r_och, r_od, r_ol);
      end else begin
        sb_exp = exp_q.pop_front();
        if ({r_och, r_od, r_ol} !== sb_exp) begin
          n_fail++;
          $display("FAIL sb_beat: got ch=%0d data=%0h last=%0b expected ch=%0d data=%0h last=%0b",
                   r_och, r_od, r_ol, sb_exp.ch, sb_exp.d, sb_exp.l);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int pop0;
    rst_n = 1'b0;
    r_v = 4'hF; r_l = 4'hF; r_d = '0; r_es = '0; r_or = 1'b1;
    f_v = '0;   f_l = 4'hF; f_d = '0; f_es = '0; f_or = 1'b1;
    e_v = '0;   e_l = '0;   e_d = '0; e_es = '0; e_or = 1'b1;

    // Reset state, with requests present
    #12;
    chk("rst_ready", r_rdy, 4'b0000);
    chk("rst_valid", r_ov, 0);
    chk("rst_data", r_od, 0);
    chk("rst_last", r_ol, 0);
    chk("rst_ch", r_och, 0);
    r_v = '0;
    @(posedge clk); #1 rst_n = 1'b1;

    // Round robin, 1-beat packets on all channels
    for (int c = 0; c < 4; c++) set_r(c, 1, 1, 8'h10 + 8'(c));
    push(0, 8'h10, 1); push(1, 8'h11, 1); push(2, 8'h12, 1); push(3, 8'h13, 1); push(0, 8'h10, 1);
    pop0 = n_pop;
    @(negedge clk);
    chk("rr_first_ready", r_rdy, 4'b0001);
    chk("rr_latency_pre", r_ov, 0);
    repeat (5) @(posedge clk);
    #1 r_v = '0;
    @(negedge clk); #1;
    chk("rr_throughput", n_pop - pop0, 5);

    // Single packet on ch1 moves the pointer to ch2
    set_r(1, 1, 1, 8'h41);
    push(1, 8'h41, 1);
    @(posedge clk); #1 r_v = '0;

    // 3-beat packet on ch2 while ch0/ch1 request; then wrap to ch0
    set_r(0, 1, 1, 8'h30);
    set_r(1, 1, 1, 8'h31);
    for (int b = 0; b < 3; b++) begin
      set_r(2, 1, (b == 2), 8'h20 + 8'(b));
      push(2, 8'h20 + 8'(b), (b == 2));
      @(negedge clk);
      chk("lock_ready", r_rdy, 4'b0100);
      @(posedge clk); #1;
    end
    set_r(2, 0, 0, 8'h00);
    push(0, 8'h30, 1);
    @(negedge clk);
    chk("wrap_ready", r_rdy, 4'b0001);
    @(posedge clk); #1 r_v = '0;

    // Backpressure with 0xA5 held, then drain and load in the same cycle
    set_r(1, 1, 1, 8'hA5);
    push(1, 8'hA5, 1);
    @(posedge clk); #1;
    set_r(1, 0, 1, 8'h00);
    set_r(0, 1, 1, 8'h5A);
    r_or = 1'b0;
    push(0, 8'h5A, 1);
    repeat (5) begin
      @(negedge clk);
      chk("bp_data", r_od, 8'hA5);
      chk("bp_valid", r_ov, 1);
      chk("bp_ready", r_rdy, 4'b0000);
    end
    @(posedge clk); #1 r_or = 1'b1;
    @(negedge clk);
    chk("drain_ready", r_rdy, 4'b0001);
    @(posedge clk); #1 r_v = '0;
    @(negedge clk); #1;
    chk("drain_load_valid", r_ov, 1);

    // Reset during beat 2 of a 4-beat ch1 packet
    @(posedge clk); #1 set_r(1, 1, 0, 8'h61);
    @(posedge clk); #1 set_r(1, 1, 0, 8'h62);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_valid", r_ov, 0);
    chk("arst_data", r_od, 0);
    chk("arst_ch", r_och, 0);
    set_r(0, 1, 1, 8'h70);
    set_r(1, 1, 1, 8'h71);
    #1 chk("arst_ready", r_rdy, 4'b0000);
    @(posedge clk); #1 rst_n = 1'b1;
    push(0, 8'h70, 1); push(1, 8'h71, 1);
    @(negedge clk);
    chk("post_rst_ready", r_rdy, 4'b0001);
    @(posedge clk); #1 set_r(0, 0, 1, 8'h00);
    @(posedge clk); #1 set_r(1, 0, 1, 8'h00);
    @(negedge clk); #1;

    // Fixed priority: ch1 beats ch3 until ch1 drops
    f_v = 4'b1010;
    f_d = {8'h33, 8'h00, 8'h11, 8'h00};
    repeat (3) begin
      @(negedge clk);
      chk("fx_ready", f_rdy, 4'b0010);
      @(posedge clk); #1;
      chk("fx_ch", f_och, 1);
      chk("fx_data", f_od, 8'h11);
    end
    f_v = 4'b1000;
    @(negedge clk);
    chk("fx_ready_ch3", f_rdy, 4'b1000);
    @(posedge clk); #1;
    chk("fx_ch3", f_och, 3);
    chk("fx_data3", f_od, 8'h33);
    f_v = '0;

    // External select: no grant when the selected channel is idle
    e_es = 2'd3;
    set_e(0, 1, 1, 8'h0E);
    repeat (2) begin
      @(negedge clk);
      chk("ex_nogrant_ready", e_rdy, 4'b0000);
      chk("ex_nogrant_valid", e_ov, 0);
    end
    @(posedge clk); #1 set_e(3, 1, 0, 8'hC0);
    @(negedge clk);
    chk("ex_grant_ready", e_rdy, 4'b1000);
    @(posedge clk); #1;
    e_es = 2'd0;
    set_e(3, 1, 0, 8'hC1);
    @(negedge clk);
    chk("ex_lock_ready", e_rdy, 4'b1000);
    chk("ex_lock_ch", e_och, 3);
    chk("ex_lock_data", e_od, 8'hC0);
    @(posedge clk); #1 set_e(3, 1, 1, 8'hC2);
    @(negedge clk);
    chk("ex_lock_ready2", e_rdy, 4'b1000);
    @(posedge clk); #1;
    chk("ex_last_data", e_od, 8'hC2);
    chk("ex_last_flag", e_ol, 1);
    set_e(3, 0, 0, 8'h00);
    @(negedge clk);
    chk("ex_release_ready", e_rdy, 4'b0001);
    @(posedge clk); #1;
    chk("ex_release_ch", e_och, 0);
    chk("ex_release_data", e_od, 8'h0E);
    e_v = '0;

    @(negedge clk); #1;
    chk("sb_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
